// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ring_ctrl
//  Description : Alarm indicator sequencer for the LCD1602 clock. Detects the
//                rising edge of the alarm/time match, rings for a bounded
//                time, supports a limited number of snoozes and drives the
//                LED/buzzer and the LCD status field.
//  Options     : ALARM_BLINK_EN - when defined, the LED blinks with period
//                2*BLINK_CYC while ringing; otherwise the LED follows ring.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl #(
  parameter int BLINK_CYC  = 5_000_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int SNOOZE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic       key_stop,
  input  logic       key_snooze,
  input  logic [3:0] alarm_hour_h,
  input  logic [3:0] alarm_hour_l,
  input  logic [3:0] alarm_min_h,
  input  logic [3:0] alarm_min_l,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  output logic       ring,
  output logic       led,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } state_e;

  // One counter serves both timed states, so size it for the longer one.
  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);

  localparam logic [SEC_W-1:0] RING_LAST    = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST  = SEC_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]       SNOOZE_LIMIT = 2'(SNOOZE_MAX);

  state_e             state_q,      state_d;
  logic [SEC_W-1:0]   sec_cnt_q,    sec_cnt_d;
  logic [1:0]         snooze_cnt_q, snooze_cnt_d;
  logic               match_q,      match_d;
  logic               ring_q,       ring_d;
  logic               led_q,        led_d;

  logic               match;
  logic               match_rise;
  logic               timed_state;

`ifdef ALARM_BLINK_EN
  localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
`endif

  // Alarm hits when every BCD digit agrees; only the first cycle of the
  // matching minute counts, so enabling mid-minute does not ring.
  always_comb begin
    match      = (alarm_hour_h == hour_h) && (alarm_hour_l == hour_l) &&
                 (alarm_min_h  == min_h)  && (alarm_min_l  == min_l);
    match_d    = match;
    match_rise = match & ~match_q;
  end

  // Next-state logic: alarm_en dominates, then per-state key/timeout rules.
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;

    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (match_rise) begin
            state_d = RINGING;
          end
        end
        RINGING: begin
          // Keys outrank the timeout; stop outranks snooze.
          if (key_stop) begin
            state_d = ARMED;
          end else if (key_snooze) begin
            if (snooze_cnt_q < SNOOZE_LIMIT) begin
              state_d      = SNOOZE;
              snooze_cnt_d = snooze_cnt_q + 2'd1;
            end else begin
              state_d = ARMED;
            end
          end else if (sec_tick && (sec_cnt_q == RING_LAST)) begin
            state_d = ARMED;
          end
        end
        SNOOZE: begin
          if (key_stop) begin
            state_d = ARMED;
          end else if (sec_tick && (sec_cnt_q == SNOOZE_LAST)) begin
            state_d = RINGING;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A new alarm event starts from a fresh snooze budget.
    if ((state_d == IDLE) || (state_d == ARMED)) begin
      snooze_cnt_d = 2'd0;
    end
  end

  // Seconds counter: restarts on any transition and only advances in the
  // timed states, where its terminal count always forces a transition.
  always_comb begin
    timed_state = (state_q == RINGING) || (state_q == SNOOZE);
    sec_cnt_d   = sec_cnt_q;
    if (state_d != state_q) begin
      sec_cnt_d = '0;
    end else if (sec_tick && timed_state) begin
      sec_cnt_d = sec_cnt_q + 1'b1;
    end
    ring_d = (state_d == RINGING);
  end

`ifdef ALARM_BLINK_EN
  // Blink: counter and LED restart at 0 on RINGING entry, LED toggles at
  // each terminal count, and both are held at 0 outside RINGING.
  always_comb begin
    blink_cnt_d = '0;
    led_d       = 1'b0;
    if ((state_d == RINGING) && (state_q == RINGING)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        led_d       = ~led_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        led_d       = led_q;
      end
    end
  end
`else
  // Steady indicator while ringing; a zero blink period disables the LED.
  always_comb begin
    led_d = ring_d & (BLINK_CYC > 0);
  end
`endif

  // State and output registers; match history resets high so a match
  // already present at reset release is not treated as a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sec_cnt_q    <= '0;
      snooze_cnt_q <= 2'd0;
      match_q      <= 1'b1;
      ring_q       <= 1'b0;
      led_q        <= 1'b0;
`ifdef ALARM_BLINK_EN
      blink_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_q      <= match_d;
      ring_q       <= ring_d;
      led_q        <= led_d;
`ifdef ALARM_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
`endif
    end
  end

  assign state      = state_q;
  assign ring       = ring_q;
  assign led        = led_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ring_ctrl
//  Description : Directed self-checking bench for alarm_ring_ctrl with a
//                scoreboard queue of expected output sets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_RING  = 2'b10;
  localparam logic [1:0] S_SNZ   = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       alarm_en = 1'b0;
  logic       key_stop = 1'b0;
  logic       key_snooze = 1'b0;
  logic [15:0] alarm_t = 16'h0730;
  logic [15:0] now_t   = 16'h0729;
  logic       ring;
  logic       led;
  logic [1:0] state;
  logic [1:0] snooze_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       rg;
    logic [1:0] sc;
    logic       led_chk;
    logic       ld;
  } exp_t;

  exp_t sb[$];

  alarm_ring_ctrl #(
    .BLINK_CYC (4),
    .RING_SEC  (4),
    .SNOOZE_SEC(3),
    .SNOOZE_MAX(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sec_tick    (sec_tick),
    .alarm_en    (alarm_en),
    .key_stop    (key_stop),
    .key_snooze  (key_snooze),
    .alarm_hour_h(alarm_t[15:12]),
    .alarm_hour_l(alarm_t[11:8]),
    .alarm_min_h (alarm_t[7:4]),
    .alarm_min_l (alarm_t[3:0]),
    .hour_h      (now_t[15:12]),
    .hour_l      (now_t[11:8]),
    .min_h       (now_t[7:4]),
    .min_l       (now_t[3:0]),
    .ring        (ring),
    .led         (led),
    .state       (state),
    .snooze_cnt  (snooze_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Generic expectation: ring follows RINGING; LED is 0 when not ringing and
  // equals ring in steady mode (blink phase is checked separately).
  task automatic push(input string tag, input logic [1:0] st, input logic [1:0] sc);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.rg  = (st == S_RING);
    e.sc  = sc;
`ifdef ALARM_BLINK_EN
    e.led_chk = !e.rg;
    e.ld      = 1'b0;
`else
    e.led_chk = 1'b1;
    e.ld      = e.rg;
`endif
    sb.push_back(e);
  endtask

  task automatic push_led(input string tag, input logic [1:0] st, input logic [1:0] sc,
                          input logic ld);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.rg  = (st == S_RING);
    e.sc  = sc;
    e.led_chk = 1'b1;
    e.ld      = ld;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (state === e.st) else begin
        n_fail++;
        $error("FAIL %s state: got %0d want %0d", e.tag, state, e.st);
      end
      n_checks++;
      assert (ring === e.rg) else begin
        n_fail++;
        $error("FAIL %s ring: got %0b want %0b", e.tag, ring, e.rg);
      end
      n_checks++;
      assert (snooze_cnt === e.sc) else begin
        n_fail++;
        $error("FAIL %s snooze_cnt: got %0d want %0d", e.tag, snooze_cnt, e.sc);
      end
      if (e.led_chk) begin
        n_checks++;
        assert (led === e.ld) else begin
          n_fail++;
          $error("FAIL %s led: got %0b want %0b", e.tag, led, e.ld);
        end
      end
    end
  endtask

  // One clock with current inputs, then compare.
  task automatic cyc(input string tag, input logic [1:0] st, input logic [1:0] sc);
    push(tag, st, sc);
    step();
    drain();
  endtask

  // One-cycle pulse on the selected strobes, then compare.
  task automatic pulse(input logic t, input logic s, input logic z, input string tag,
                       input logic [1:0] st, input logic [1:0] sc);
    sec_tick   = t;
    key_stop   = s;
    key_snooze = z;
    push(tag, st, sc);
    step();
    sec_tick   = 1'b0;
    key_stop   = 1'b0;
    key_snooze = 1'b0;
    drain();
  endtask

  // Leave the alarm minute and come back to create a fresh match edge.
  task automatic ring_up(input string tag);
    now_t = 16'h0731;
    step();
    now_t = 16'h0730;
    cyc(tag, S_RING, 2'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    push("reset", S_IDLE, 2'd0);
    drain();
    rst = 1'b0;

    // 1: basic ring with latency and timeout
    alarm_en = 1'b1;
    cyc("arm", S_ARMED, 2'd0);
    now_t = 16'h0730;
    push("pre_ring", S_ARMED, 2'd0);
    drain();
    cyc("ring_latency", S_RING, 2'd0);
`ifdef ALARM_BLINK_EN
    push_led("ring_entry_led", S_RING, 2'd0, 1'b0);
    drain();
`endif
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, "ring_tick", S_RING, 2'd0);
    pulse(1, 0, 0, "ring_timeout", S_ARMED, 2'd0);
    cyc("no_rering", S_ARMED, 2'd0);

    // 2: snooze sequence up to the limit
    ring_up("ring2");
    pulse(0, 0, 1, "snooze1", S_SNZ, 2'd1);
    for (int i = 0; i < 2; i++) pulse(1, 0, 0, "snz1_tick", S_SNZ, 2'd1);
    pulse(1, 0, 0, "snz1_end", S_RING, 2'd1);
    pulse(0, 0, 1, "snooze2", S_SNZ, 2'd2);
    pulse(0, 0, 1, "snz_key_ignored", S_SNZ, 2'd2);
    for (int i = 0; i < 2; i++) pulse(1, 0, 0, "snz2_tick", S_SNZ, 2'd2);
    pulse(1, 0, 0, "snz2_end", S_RING, 2'd2);
    pulse(0, 0, 1, "snooze_limit_stop", S_ARMED, 2'd0);

    // 3: stop beats snooze
    ring_up("ring3");
    pulse(0, 1, 1, "stop_and_snooze", S_ARMED, 2'd0);

    // match edge ignored while ringing; key beats coincident timeout
    ring_up("ring3b");
    pulse(1, 0, 0, "r3b_tick1", S_RING, 2'd0);
    now_t = 16'h0731;
    step();
    now_t = 16'h0730;
    cyc("rise_ignored", S_RING, 2'd0);
    for (int i = 0; i < 2; i++) pulse(1, 0, 0, "r3b_tick", S_RING, 2'd0);
    pulse(1, 0, 1, "key_over_timeout", S_SNZ, 2'd1);
    pulse(0, 1, 0, "snz_stop", S_ARMED, 2'd0);

    // 4: enabling during the matching minute does not ring
    alarm_en = 1'b0;
    cyc("disable", S_IDLE, 2'd0);
    alarm_en = 1'b1;
    cyc("enable_in_match", S_ARMED, 2'd0);
    cyc("no_ring_on_enable", S_ARMED, 2'd0);
    ring_up("ring4");

    // 5: disable while ringing, reset mid-snooze
    alarm_en = 1'b0;
    cyc("en_off_ringing", S_IDLE, 2'd0);
    alarm_en = 1'b1;
    cyc("rearm", S_ARMED, 2'd0);
    ring_up("ring5");
    pulse(0, 0, 1, "snooze5", S_SNZ, 2'd1);
    rst = 1'b1;
    cyc("rst_mid_snooze", S_IDLE, 2'd0);
    rst = 1'b0;
    cyc("after_rst_arm", S_ARMED, 2'd0);
    cyc("match_at_release", S_ARMED, 2'd0);

    // 6: indicator pattern while ringing
    ring_up("ring6");
    for (int k = 1; k < 12; k++) begin
`ifdef ALARM_BLINK_EN
      push_led("blink", S_RING, 2'd0, logic'((k / 4) % 2));
`else
      push_led("steady_led", S_RING, 2'd0, 1'b1);
`endif
      step();
      drain();
    end
    pulse(0, 1, 0, "final_stop", S_ARMED, 2'd0);
    push_led("led_off_after", S_ARMED, 2'd0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
